datapath: RTL and testbench

- Top-level datapath for the SNES-controller demo.
- Periodically polls an SNES controller over its latch/clock/serial-data protocol and stores the 16 button states.
- Updates a 16-bit position register through a small add/subtract ALU.
- Shows the register in hex on four active-low 7-segment digits.

---
 rtl/datapath_pkg.sv | 59 +++++
 rtl/datapath_snes_reader.sv | 106 ++++++++++
 rtl/datapath.sv | 58 +++++
 tb/tb_datapath.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the SNES-controller demo datapath: button indices,
// poll state encoding and hex-to-7-segment helpers.
package datapath_pkg;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    UPDATE
  } poll_state_t;

  localparam logic [27:0] SEG_ZERO4 = 28'h8102040;

  // Active-low segments, bit0 = a ... bit6 = g
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    seg = 7'h7F;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  function automatic logic [27:0] hex4_to_seg(input logic [15:0] v);
    return {hex_to_seg(v[15:12]), hex_to_seg(v[11:8]),
            hex_to_seg(v[7:4]), hex_to_seg(v[3:0])};
  endfunction

endpackage

// File: rtl/datapath_snes_reader.sv
// SNES controller poller: latch pulse, 15 clock pulses, 16-bit capture,
// then a one-cycle valid strobe alongside the freshly loaded buttons word.
//
// state  | meaning
// IDLE   | wait POLL_GAP cycles between polls
// LATCH  | data_latch high for 2*HALF_PERIOD, bit0 captured on exit
// LOW    | snes_clk low for HALF_PERIOD
// HIGH   | snes_clk high for HALF_PERIOD, bit[idx] captured on first cycle
// UPDATE | buttons <= ~shift, strobe valid
module snes_reader
  import datapath_pkg::*;
#(
  parameter int HALF_PERIOD = 600,
  parameter int POLL_GAP    = 1666000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_data,
  output logic        snes_clk,
  output logic        data_latch,
  output logic [15:0] buttons,
  output logic        valid
);

  localparam int CNT_MAX = (POLL_GAP > 2 * HALF_PERIOD) ? POLL_GAP : 2 * HALF_PERIOD;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] GAP_TC   = CW'(POLL_GAP - 1);
  localparam logic [CW-1:0] LATCH_TC = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] HALF_TC  = CW'(HALF_PERIOD - 1);

  poll_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic          tc;
  logic [3:0]    idx;
  logic [15:0]   shift;
  logic          sd_r;

  always_comb begin
    state_next = state;
    tc         = 1'b0;
    case (state)
      IDLE: begin
        tc = (cnt == GAP_TC);
        if (tc) state_next = LATCH;
      end
      LATCH: begin
        tc = (cnt == LATCH_TC);
        if (tc) state_next = LOW;
      end
      LOW: begin
        tc = (cnt == HALF_TC);
        if (tc) state_next = HIGH;
      end
      HIGH: begin
        tc = (cnt == HALF_TC);
        if (tc) state_next = (idx == 4'd15) ? UPDATE : LOW;
      end
      UPDATE: begin
        tc         = 1'b1;
        state_next = IDLE;
      end
      default: begin
        tc         = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      sd_r    <= 1'b0;
      buttons <= '0;
      valid   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= tc ? '0 : cnt + CW'(1);
      sd_r  <= serial_data;
      valid <= 1'b0;
      case (state)
        LATCH: if (tc) begin
          shift[0] <= sd_r;
          idx      <= 4'd1;
        end
        HIGH: begin
          // sd_r here reflects the line as it stood while snes_clk was low
          if (cnt == '0) shift[idx] <= sd_r;
          if (tc) idx <= idx + 4'd1;
        end
        UPDATE: begin
          buttons <= ~shift;
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign snes_clk   = (state != LOW);
  assign data_latch = (state == LATCH);

endmodule

// File: rtl/datapath.sv
// SNES demo top: polls the controller, moves a 16-bit position with the
// d-pad/A/B, and shows it in hex. Define SHOW_BUTTONS_EN to display the raw buttons.
module datapath
  import datapath_pkg::*;
#(
  parameter int HALF_PERIOD = 600,
  parameter int POLL_GAP    = 1666000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        serial_data,
  output logic        snes_clk,
  output logic        data_latch,
  output logic [27:0] display
);

  logic [15:0] buttons;
  logic        btn_valid;
  logic [15:0] position;
  logic [15:0] delta;

  snes_reader #(
    .HALF_PERIOD (HALF_PERIOD),
    .POLL_GAP    (POLL_GAP)
  ) u_reader (
    .clk         (clk),
    .reset       (reset),
    .serial_data (serial_data),
    .snes_clk    (snes_clk),
    .data_latch  (data_latch),
    .buttons     (buttons),
    .valid       (btn_valid)
  );

  // Opposing pairs cancel naturally because both terms are summed
  always_comb begin
    delta = '0;
    if (buttons[BTN_UP])   delta = delta + 16'h0001;
    if (buttons[BTN_DOWN]) delta = delta - 16'h0001;
    if (buttons[BTN_A])    delta = delta + 16'h0010;
    if (buttons[BTN_B])    delta = delta - 16'h0010;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      position <= '0;
    end else if (btn_valid) begin
      position <= position + delta;
    end
  end

`ifdef SHOW_BUTTONS_EN
  assign display = hex4_to_seg(buttons);
`else
  assign display = hex4_to_seg(position);
`endif

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: a controller model drives serial_data, a reference
// model predicts position per poll, and a monitor checks each update and the poll waveform.
module tb_datapath;

  localparam int HALF = 2;
  localparam int GAP  = 8;
  localparam logic [27:0] ZERO4 = 28'h8102040;

  logic        clk = 1'b0;
  logic        reset;
  logic        serial_data;
  logic        snes_clk;
  logic        data_latch;
  logic [27:0] display;

  datapath #(.HALF_PERIOD(HALF), .POLL_GAP(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .serial_data (serial_data),
    .snes_clk    (snes_clk),
    .data_latch  (data_latch),
    .display     (display)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] pos;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] ctrl_word  = 16'h0000;
  logic [15:0] model_pos  = 16'h0000;
  int          k          = 16;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [27:0] seg4(input logic [15:0] v);
    return {seg_tab[v[15:12]], seg_tab[v[11:8]], seg_tab[v[7:4]], seg_tab[v[3:0]]};
  endfunction

  function automatic logic [15:0] next_pos(input logic [15:0] pos, input logic [15:0] w);
    int d;
    d = 0;
    if (w[4]) d = d + 1;
    if (w[5]) d = d - 1;
    if (w[8]) d = d + 16;
    if (w[0]) d = d - 16;
    return pos + 16'(d);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Controller model: bit0 presented while latched, next bit on each falling snes_clk
  always @(posedge data_latch or negedge snes_clk) begin
    if (data_latch) k = 0;
    else if (k < 16) k = k + 1;
  end
  assign serial_data = (k < 16) ? ~ctrl_word[k[3:0]] : 1'b0;

  int   lat_c = 0, low_c = 0, pulses = 0;
  logic prev_sc = 1'b1;
  logic pend = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      lat_c = 0; low_c = 0; pulses = 0; prev_sc = 1'b1; pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_update: display %h with empty scoreboard", display);
        end else begin
          mon_e = sb.pop_front();
          chk("buttons", dut.buttons, mon_e.word);
          chk("display", display, seg4(mon_e.pos));
        end
      end
      if (data_latch) lat_c++;
      if (!snes_clk) low_c++;
      if (prev_sc && !snes_clk) pulses++;
      prev_sc = snes_clk;
      if (dut.btn_valid) begin
        chk("latch_cycles", lat_c, 2 * HALF);
        chk("clk_pulses", pulses, 15);
        chk("clk_low_cycles", low_c, 15 * HALF);
        lat_c = 0; low_c = 0; pulses = 0;
        pend = 1'b1;
      end
    end
  end

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, done, 1'b1);
  endtask

  task automatic poll(input logic [15:0] w);
    exp_t e;
    ctrl_word = w;
    model_pos = next_pos(model_pos, w);
    e.word = w;
    e.pos  = model_pos;
    sb.push_back(e);
    wait_drain("poll_done");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_pos = 16'h0000;
    sb.delete();
    #1;
    chk("rst_snes_clk", snes_clk, 1'b1);
    chk("rst_latch", data_latch, 1'b0);
    chk("rst_display", display, ZERO4);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic        seen;
    int          n;
    logic [15:0] w;
    exp_t        e;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_snes_clk", snes_clk, 1'b1);
    chk("init_latch", data_latch, 1'b0);
    chk("init_display", display, ZERO4);
    reset = 1'b0;

    // no controller: all lines idle high
    poll(16'h0000);
    poll(16'h0000);
    chk("idle_display", display, ZERO4);

    poll(16'h0010);
    chk("up_display", display, 28'h8102079);

    do_reset();
    poll(16'h0020);
    chk("down_wrap_display", display, 28'h1C3870E);

    do_reset();
    poll(16'h0100);
    chk("a_display", display, 28'h8103CC0);
    poll(16'h0030);
    chk("up_down_cancel", display, 28'h8103CC0);
    poll(16'h0101);
    chk("a_b_cancel", display, 28'h8103CC0);

    for (int i = 0; i < 24; i++) begin
      w = 16'($urandom);
      if ((i % 5) == 0) w = 16'h0000;
      poll(w);
    end

    // reset while snes_clk is high mid-poll
    ctrl_word = 16'h0010;
    seen = 1'b0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      if (pulses >= 5 && pulses < 15 && snes_clk && !data_latch) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_high_phase", seen, 1'b1);
    reset = 1'b1;
    model_pos = 16'h0000;
    sb.delete();
    #1;
    chk("mid_rst_snes_clk", snes_clk, 1'b1);
    chk("mid_rst_latch", data_latch, 1'b0);
    chk("mid_rst_display", display, ZERO4);
    chk("mid_rst_buttons", dut.buttons, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_pos = next_pos(model_pos, ctrl_word);
    e.word = ctrl_word;
    e.pos  = model_pos;
    sb.push_back(e);
    n = 0;
    for (int j = 1; j <= 200; j++) begin
      @(negedge clk);
      if (data_latch) begin
        n = j;
        break;
      end
    end
    chk("restart_gap", n, GAP);
    wait_drain("post_reset_poll");
    chk("post_reset_display", display, 28'h8102079);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
